centroid_defuzzifier: RTL and testbench
=======================================

CENTROID_DEFUZZIFIER -- requirements
Module: centroid_defuzzifier

Interface
REQ-001 Parameter: LongBits_limit, default 10, width of the membership bit vector N (same value as the cut-line stage feeding this block).
REQ-002 Derived: IW = $clog2(N); CW = $clog2(N+1); SW = $clog2(N*(N-1)/2 + N/2 + 1). For N=10: IW=4, CW=4, SW=6.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  membership vector on z_in is valid.
REQ-006 in_ready  output  1  block accepts a vector.
REQ-007 z_in  input  N  membership vector from the cut-line stage; bit i set = universe point i is a member.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 centroid  output  IW  defuzzified crisp index.
REQ-011 count  output  CW  number of set bits in the accepted vector.
REQ-012 empty  output  1  accepted vector was all zeros.

Function
REQ-013 States: IDLE, SCAN, DIV, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Accept on the edge where in_valid & in_ready: capture z_in, clear accumulators, go to SCAN with bit index 0.
REQ-015 SCAN: one bit per edge, index 0..N-1; on a set bit, count += 1 and sum += index. Exactly N edges in SCAN.
REQ-016 On the Nth SCAN edge: count==0 -> DONE with empty=1, centroid=0; otherwise -> DIV.
REQ-017 DIV: restoring division of dividend by count, one quotient bit per edge, exactly SW edges, MSB first; then DONE.
REQ-018 Dividend = sum (truncating mode) or sum + floor(count/2) (rounding mode, see REQ-026); quotient truncated to IW bits, never exceeds N-1.
REQ-019 Latency: out_valid rises N+SW edges after the accepting edge (16 for N=10); N edges when empty (10 for N=10).
REQ-020 DONE: centroid, count, empty held stable while out_valid=1 and out_ready=0.
REQ-021 DONE with out_ready=1: go to IDLE on that edge; no accept in the same cycle (in_ready low in DONE).
REQ-022 in_valid while not in IDLE is ignored; z_in changes after accept do not affect the result.

Reset
REQ-023 rst=1 at an edge: state=IDLE, in_ready=1 on the following cycle, out_valid=0, centroid=0, count=0, empty=0, all accumulators and divider registers cleared.
REQ-024 rst in any state (SCAN, DIV, DONE mid-handshake) abandons the operation; no partial result is ever presented.
REQ-025 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-026 Macro CENTROID_ROUND_EN: defined -> dividend = sum + floor(count/2), giving round-half-up; undefined -> dividend = sum, giving floor. Latency, interface and empty behaviour are identical in both builds.

Verification
REQ-027 z_in=10'b0000011100 -> count=3, centroid=3 (both builds), empty=0, out_valid exactly 16 edges after accept.
REQ-028 z_in=10'b1000000001 -> count=2, sum=9; centroid=4 without CENTROID_ROUND_EN, 5 with it.
REQ-029 z_in=10'b1111111111 -> count=10, sum=45; centroid=4 truncating, 5 rounding.
REQ-030 z_in=0 -> empty=1, count=0, centroid=0, out_valid 10 edges after accept.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/z_in -> outputs stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-032 Assert rst on the 5th SCAN edge -> next cycle in_ready=1, out_valid=0; the next vector processes with correct result and full latency.

Source files
------------

// File: rtl/centroid_defuzzifier.sv
`default_nettype none
// ============================================================================
// Module   : centroid_defuzzifier
// Purpose  : Centroid of a membership bit vector: serial bit scan followed by
//            serial restoring division (sum / count). Defining
//            CENTROID_ROUND_EN rounds half-up instead of truncating.
// Revision : 1.0 - initial release
// ============================================================================
module centroid_defuzzifier #(
    parameter int LongBits_limit = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LongBits_limit-1:0]              z_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [$clog2(LongBits_limit)-1:0]      centroid,
    output logic [$clog2(LongBits_limit+1)-1:0]    count,
    output logic                                   empty
);

    localparam int N  = LongBits_limit;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(N * (N - 1) / 2 + N / 2 + 1);
    localparam int DW = $clog2(SW + 1);

    localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);
    localparam logic [DW-1:0] c_DIV_LAST = DW'(SW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [N-1:0]    r_z;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_sum;
    logic [SW-1:0]   r_dvd;
    logic [CW-1:0]   r_rem;
    logic [IW-1:0]   r_quot;
    logic [DW-1:0]   r_div_cnt;
    logic            r_empty;

    logic            w_bit;
    logic            w_last;
    logic [CW-1:0]   w_count_next;
    logic [SW-1:0]   w_sum_next;
    logic [SW-1:0]   w_dividend;
    logic [CW:0]     w_trial;
    logic            w_ge;
    logic [CW-1:0]   w_diff;

    assign w_bit        = r_z[0];
    assign w_last       = (r_idx == c_LAST_IDX);
    assign w_count_next = r_count + CW'(w_bit);
    assign w_sum_next   = w_bit ? (r_sum + SW'(r_idx)) : r_sum;

`ifdef CENTROID_ROUND_EN
    // Adding half the divisor turns the floor division into round-half-up.
    assign w_dividend   = w_sum_next + SW'(w_count_next >> 1);
`else
    assign w_dividend   = w_sum_next;
`endif

    // Remainder stays below count, so the difference fits in CW bits.
    assign w_trial      = {r_rem, r_dvd[SW-1]};
    assign w_ge         = (w_trial >= {1'b0, r_count});
    assign w_diff       = w_trial[CW-1:0] - r_count;

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign centroid     = r_quot;
    assign count        = r_count;
    assign empty        = r_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_next = SCAN;
            SCAN: if (w_last) w_state_next = (w_count_next == '0) ? DONE : DIV;
            DIV:  if (r_div_cnt == c_DIV_LAST) w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z       <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_sum     <= '0;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_div_cnt <= '0;
            r_empty   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_z       <= z_in;
                        r_idx     <= '0;
                        r_count   <= '0;
                        r_sum     <= '0;
                        r_dvd     <= '0;
                        r_rem     <= '0;
                        r_quot    <= '0;
                        r_div_cnt <= '0;
                        r_empty   <= 1'b0;
                    end
                end
                SCAN: begin
                    r_z     <= {1'b0, r_z[N-1:1]};
                    r_idx   <= r_idx + 1'b1;
                    r_count <= w_count_next;
                    r_sum   <= w_sum_next;
                    if (w_last) begin
                        r_dvd     <= w_dividend;
                        r_rem     <= '0;
                        r_div_cnt <= '0;
                        r_empty   <= (w_count_next == '0);
                    end
                end
                DIV: begin
                    // Quotient wider than IW bits is impossible; high bits shift out as zeros.
                    r_rem     <= w_ge ? w_diff : w_trial[CW-1:0];
                    r_dvd     <= {r_dvd[SW-2:0], 1'b0};
                    r_quot    <= {r_quot[IW-2:0], w_ge};
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_centroid_defuzzifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_centroid_defuzzifier
// Purpose  : Directed self-checking bench for centroid_defuzzifier (N=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_centroid_defuzzifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] z_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] centroid;
    logic [3:0] count;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CENTROID_ROUND_EN
    localparam int c_ROUND = 1;
`else
    localparam int c_ROUND = 0;
`endif

    centroid_defuzzifier #(.LongBits_limit(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .centroid  (centroid),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [9:0] z, input int exp_cnt,
                           input int exp_cent, input int exp_empty, input int exp_lat);
        int lat;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        z_in     = z;
        step();
        in_valid = 1'b0;
        z_in     = ~z;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"},  32'(lat),      32'(exp_lat));
        check({tag, "_count"},    32'(count),    32'(exp_cnt));
        check({tag, "_centroid"}, 32'(centroid), 32'(exp_cent));
        check({tag, "_empty"},    32'(empty),    32'(exp_empty));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        z_in      = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_centroid",  32'(centroid),  32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_empty",     32'(empty),     32'd0);

        // Points 2,3,4: sum 9 / 3 = 3 in either mode.
        run_vec("v_mid3",  10'b0000011100, 3, 3, 0, 16);
        // Points 0,9: 9/2 = 4.5.
        run_vec("v_ends",  10'b1000000001, 2, 4 + c_ROUND, 0, 16);
        // All points: 45/10 = 4.5.
        run_vec("v_full",  10'b1111111111, 10, 4 + c_ROUND, 0, 16);
        run_vec("v_empty", 10'b0000000000, 0, 0, 1, 10);
        run_vec("v_single8", 10'b0100000000, 1, 8, 0, 16);
        // Points 0,1: 1/2 = 0.5.
        run_vec("v_low2",  10'b0000000011, 2, 0 + c_ROUND, 0, 16);

        // Backpressure in DONE while in_valid/z_in toggle.
        in_valid = 1'b1;
        z_in     = 10'b0000011100;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) step();
        check("hold_out_valid_entry", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            z_in     = 10'(k * 97);
            step();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_centroid",  32'(centroid),  32'd3);
            check("hold_count",     32'(count),     32'd3);
            check("hold_empty",     32'(empty),     32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_release_in_ready",  32'(in_ready),  32'd1);
        check("hold_release_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 20; k++) step();
        check("hold_no_accept", 32'(out_valid), 32'd0);

        // Reset on the 5th SCAN edge abandons the operation.
        in_valid = 1'b1;
        z_in     = 10'b1111111111;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count",     32'(count),     32'd0);
        check("midrst_centroid",  32'(centroid),  32'd0);
        check("midrst_empty",     32'(empty),     32'd0);
        run_vec("v_after_rst", 10'b1000000001, 2, 4 + c_ROUND, 0, 16);

        // Reset wins over a simultaneous in_valid.
        rst      = 1'b1;
        in_valid = 1'b1;
        z_in     = 10'b0000000100;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rstprio_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 20; k++) step();
        check("rstprio_no_result", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
